// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - OKI ADPCM tables and constants shared by the JT6295 decode stage
package jt6295_pkg;

  localparam int SIG_MAX = 2047;
  localparam int SIG_MIN = -2048;
  localparam int IDX_MAX = 48;

  localparam logic [10:0] STEP [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // +8 does not fit a signed nibble, so the adjustment entries carry one extra bit
  localparam logic signed [4:0] ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  localparam logic [5:0] GAIN [0:15] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
    6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
  };

endpackage

// File: rtl/jt6295_adpcm_rom.sv
// rtl/jt6295_adpcm_rom.sv - combinational OKI step-size lookup
module jt6295_adpcm_rom
  import jt6295_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [10:0] step
);

  logic [5:0] idx_safe;

  always_comb begin
    idx_safe = (idx > 6'(IDX_MAX)) ? 6'(IDX_MAX) : idx;
    step     = STEP[idx_safe];
  end

endmodule

// File: rtl/jt6295_adpcm_stage.sv
// rtl/jt6295_adpcm_stage.sv - time-multiplexed OKI ADPCM decode stage, 2-cycle state / 3-cycle sound latency
module jt6295_adpcm_stage
  import jt6295_pkg::*;
#(
  parameter int CH = 4,
  parameter int SW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          en,
  input  logic          start,
  input  logic [3:0]    data,
  input  logic [3:0]    att,
  input  logic [SW-1:0] sig_in,
  input  logic [5:0]    idx_in,
  output logic [SW-1:0] sig_out,
  output logic [5:0]    idx_out,
  output logic [SW-1:0] sound
);

  // The external delay line closes the state loop, so it needs at least one stage
  if (CH < 3) begin : g_ch_check
    $error("jt6295_adpcm_stage: CH must be at least 3");
  end

  logic [5:0]           idx_e;
  logic [10:0]          step_w;
  logic signed [7:0]    idx_sum;
  logic [SW:0]          delta;
  logic signed [SW+1:0] sig_ext;
  logic signed [SW+1:0] sum;
  logic signed [SW+6:0] prod;

  logic [SW-1:0] a_sig_q,   a_sig_d;
  logic [10:0]   a_step_q,  a_step_d;
  logic [5:0]    a_idx_q,   a_idx_d;
  logic          a_sign_q,  a_sign_d;
  logic [2:0]    a_mag_q,   a_mag_d;
  logic          a_en_q,    a_en_d;
  logic [3:0]    a_att_q,   a_att_d;
  logic [SW-1:0] sig_out_q, sig_out_d;
  logic [5:0]    idx_out_q, idx_out_d;
  logic          b_en_q,    b_en_d;
  logic [3:0]    b_att_q,   b_att_d;
  logic [SW-1:0] sound_q,   sound_d;

  jt6295_adpcm_rom u_rom (
    .idx  (idx_e),
    .step (step_w)
  );

  always_comb begin
    idx_e    = start ? 6'd0 : ((idx_in > 6'(IDX_MAX)) ? 6'(IDX_MAX) : idx_in);
    idx_sum  = $signed({2'b00, idx_e}) + 8'(ADJ[data[2:0]]);
    a_sig_d  = start ? '0 : sig_in;
    a_step_d = step_w;
    if (idx_sum < 0)
      a_idx_d = 6'd0;
    else if (idx_sum > IDX_MAX)
      a_idx_d = 6'(IDX_MAX);
    else
      a_idx_d = 6'(idx_sum);
    a_sign_d = data[3];
    a_mag_d  = data[2:0];
    a_en_d   = en;
    a_att_d  = att;
  end

  always_comb begin
    delta = (SW+1)'(a_step_q >> 3)
          + (a_mag_q[2] ? (SW+1)'(a_step_q)      : '0)
          + (a_mag_q[1] ? (SW+1)'(a_step_q >> 1) : '0)
          + (a_mag_q[0] ? (SW+1)'(a_step_q >> 2) : '0);
    sig_ext = {{2{a_sig_q[SW-1]}}, a_sig_q};
    sum     = a_sign_q ? (sig_ext - $signed({1'b0, delta}))
                       : (sig_ext + $signed({1'b0, delta}));
    if (!a_en_q)
      sig_out_d = '0;
    else if (sum > SIG_MAX)
      sig_out_d = SW'(SIG_MAX);
    else if (sum < SIG_MIN)
      sig_out_d = SW'(SIG_MIN);
    else
      sig_out_d = SW'(sum);
    idx_out_d = a_en_q ? a_idx_q : 6'd0;
    b_en_d    = a_en_q;
    b_att_d   = a_att_q;
  end

  always_comb begin
    prod    = $signed(sig_out_q) * $signed({1'b0, GAIN[b_att_q]});
    sound_d = b_en_q ? SW'(prod >>> 5) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sig_q   <= '0;
      a_step_q  <= '0;
      a_idx_q   <= '0;
      a_sign_q  <= 1'b0;
      a_mag_q   <= '0;
      a_en_q    <= 1'b0;
      a_att_q   <= '0;
      sig_out_q <= '0;
      idx_out_q <= '0;
      b_en_q    <= 1'b0;
      b_att_q   <= '0;
      sound_q   <= '0;
    end else if (cen) begin
      a_sig_q   <= a_sig_d;
      a_step_q  <= a_step_d;
      a_idx_q   <= a_idx_d;
      a_sign_q  <= a_sign_d;
      a_mag_q   <= a_mag_d;
      a_en_q    <= a_en_d;
      a_att_q   <= a_att_d;
      sig_out_q <= sig_out_d;
      idx_out_q <= idx_out_d;
      b_en_q    <= b_en_d;
      b_att_q   <= b_att_d;
      sound_q   <= sound_d;
    end
  end

  assign sig_out = sig_out_q;
  assign idx_out = idx_out_q;
  assign sound   = sound_q;

endmodule
